// File: rtl/l2_request_arbiter_if.sv
// Bundle of the L2 request path: per-port requests, the reservation-tracking side
// channel, the memory-side forward handshake and SC completion reporting.
interface l2_request_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ID_W      = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]    req_valid;
  logic [NUM_PORTS-1:0]    req_ready;
  logic [NUM_PORTS*30-1:0] req_addr;
  logic [NUM_PORTS-1:0]    req_lr;
  logic [NUM_PORTS-1:0]    req_sc;
  logic [NUM_PORTS-1:0]    req_store;

  logic                    rsv_strobe;
  logic [29:0]             rsv_addr;
  logic [ID_W-1:0]         rsv_id;
  logic                    rsv_lr;
  logic                    rsv_sc;
  logic                    rsv_store;
  logic                    rsv_abort;

  logic                    mem_valid;
  logic                    mem_ready;
  logic [29:0]             mem_addr;
  logic [ID_W-1:0]         mem_id;
  logic                    mem_lr;
  logic                    mem_sc;
  logic                    mem_store;

  logic                    sc_done;
  logic [ID_W-1:0]         sc_done_id;
  logic                    sc_success;

  // The arbiter itself.
  modport slave (
    input  req_valid, req_addr, req_lr, req_sc, req_store,
    input  rsv_abort, mem_ready,
    output req_ready,
    output rsv_strobe, rsv_addr, rsv_id, rsv_lr, rsv_sc, rsv_store,
    output mem_valid, mem_addr, mem_id, mem_lr, mem_sc, mem_store,
    output sc_done, sc_done_id, sc_success
  );

  // Requesters, reservation logic and memory pipeline seen as one environment.
  modport master (
    output req_valid, req_addr, req_lr, req_sc, req_store,
    output rsv_abort, mem_ready,
    input  req_ready,
    input  rsv_strobe, rsv_addr, rsv_id, rsv_lr, rsv_sc, rsv_store,
    input  mem_valid, mem_addr, mem_id, mem_lr, mem_sc, mem_store,
    input  sc_done, sc_done_id, sc_success
  );
endinterface

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter for the shared L2 request path: one grant per cycle, reservation
// check for LR/SC/store, one-entry holding register towards memory, SC result reporting.
module l2_request_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  l2_request_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_ABORTED = 2'd2
  } state_e;

  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_PORTS - 1);
  localparam logic [ID_W:0]   PORTS_EXT = (ID_W + 1)'(NUM_PORTS);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;

  logic [29:0]     r_addr;
  logic [ID_W-1:0] r_id;
  logic            r_lr;
  logic            r_sc;
  logic            r_store;

  logic            w_found;
  logic [ID_W-1:0] w_sel;
  logic            w_can_grant;
  logic            w_grant;
  logic            w_abort_sc;

  // Search from r_rr_ptr upwards, wrapping; a non-power-of-two port count needs the
  // explicit wrap rather than relying on counter overflow.
  always_comb begin
    logic [ID_W:0] cand;
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
      if (cand >= PORTS_EXT) cand = cand - PORTS_EXT;
      if (!w_found && bus.req_valid[cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = cand[ID_W-1:0];
      end
    end
  end

  assign bus.rsv_addr  = bus.req_addr[int'(w_sel) * 30 +: 30];
  assign bus.rsv_id    = w_sel;
  assign bus.rsv_lr    = bus.req_lr[w_sel];
  assign bus.rsv_sc    = bus.req_sc[w_sel];
  assign bus.rsv_store = bus.req_store[w_sel];

  // A pending entry only blocks new grants while memory is stalling it.
  assign w_can_grant = (r_state != ST_PENDING) || bus.mem_ready;
  assign w_grant     = !rst && w_can_grant && w_found;
  assign w_abort_sc  = bus.req_sc[w_sel] && bus.rsv_abort;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of the order the simulator evaluates blocks in.
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_rr_ptr <= (w_sel == LAST_ID) ? '0 : w_sel + 1'b1;
    end
  end

  // NOTE: the payload is qualified by r_state, so it needs no reset; leaving it out
  // keeps the reset net off 30+ data flops.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr  <= bus.rsv_addr;
      r_id    <= w_sel;
      r_lr    <= bus.rsv_lr;
      r_sc    <= bus.rsv_sc;
      r_store <= bus.rsv_store;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path through
    // the case/if leaves a signal unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    bus.req_ready  = '0;
    bus.rsv_strobe = 1'b0;
    bus.mem_valid  = 1'b0;
    bus.sc_done    = 1'b0;
    bus.sc_success = 1'b0;

    case (r_state)
      ST_PENDING: begin
        bus.mem_valid = 1'b1;
        if (bus.mem_ready) begin
          w_state_nxt    = ST_EMPTY;
          bus.sc_done    = r_sc;
          bus.sc_success = 1'b1;
        end
      end
      ST_ABORTED: begin
        w_state_nxt = ST_EMPTY;
        bus.sc_done = 1'b1;
      end
      default: ;
    endcase

    // A grant in the same cycle as a drain simply refills the register.
    if (w_grant) begin
      bus.req_ready[w_sel] = 1'b1;
      bus.rsv_strobe       = 1'b1;
      w_state_nxt          = w_abort_sc ? ST_ABORTED : ST_PENDING;
    end
  end

  assign bus.mem_addr   = r_addr;
  assign bus.mem_id     = r_id;
  assign bus.mem_lr     = r_lr;
  assign bus.mem_sc     = r_sc;
  assign bus.mem_store  = r_store;
  assign bus.sc_done_id = r_id;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.mem_valid && !bus.mem_ready) |=> (bus.mem_valid && $stable(bus.mem_addr)
                                           && $stable(bus.mem_id)));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomised and directed bench for l2_request_arbiter against a queue-based model of
// the arbitration, holding register and SC reporting rules.
module tb_l2_request_arbiter;
  localparam int NP = 3;
  localparam int IW = $clog2(NP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_request_arbiter_if #(.NUM_PORTS(NP), .ID_W(IW)) bus ();

  l2_request_arbiter #(.NUM_PORTS(NP), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [29:0] addr;
    bit          lr;
    bit          sc;
    bit          st;
  } req_t;

  req_t rq [NP][$];
  req_t cur [NP];
  bit   cur_v [NP];
  bit   rand_mode   = 1'b0;
  bit   mem_ready_v = 1'b1;
  bit   abort_v     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the holding register as "forwarded entry present" / "aborted SC present".
  bit          m_full  = 1'b0;
  bit          m_abort = 1'b0;
  req_t        m_ent;
  int          m_id    = 0;
  int          m_ptr   = 0;
  bit [NP-1:0] m_last_gnt = '0;
  int          m_wait [NP];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_arb(output bit gnt, output int g);
    gnt = 1'b0;
    g   = 0;
    if (rst) return;
    if (m_full && !bus.mem_ready) return;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_ptr + k) % NP;
      if (bus.req_valid[p]) begin
        gnt = 1'b1;
        g   = p;
        return;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit gnt;
    int g;
    model_arb(gnt, g);
    m_last_gnt = '0;
    if (rst) begin
      m_full  = 1'b0;
      m_abort = 1'b0;
      m_ptr   = 0;
      for (int p = 0; p < NP; p++) m_wait[p] = 0;
    end else if (gnt) begin
      for (int p = 0; p < NP; p++)
        if (p != g && bus.req_valid[p]) m_wait[p]++;
      check("starvation_bound", 64'(m_wait[g] <= NP - 1), 64'd1);
      m_wait[g]     = 0;
      m_ent         = cur[g];
      m_id          = g;
      m_last_gnt[g] = 1'b1;
      if (cur[g].sc && bus.rsv_abort) begin
        m_abort = 1'b1;
        m_full  = 1'b0;
      end else begin
        m_abort = 1'b0;
        m_full  = 1'b1;
      end
      m_ptr = (g + 1) % NP;
    end else begin
      if (m_full && bus.mem_ready) m_full = 1'b0;
      m_abort = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit          gnt;
    int          g;
    bit          exp_done;
    logic [NP-1:0] exp_rr;
    if (!rst) begin
      model_arb(gnt, g);
      exp_rr = gnt ? (NP'(1) << g) : '0;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rr));
      check("rsv_strobe", 64'(bus.rsv_strobe), 64'(gnt));
      if (gnt) begin
        check("rsv_id", 64'(bus.rsv_id), 64'(g));
        check("rsv_addr", 64'(bus.rsv_addr), 64'(cur[g].addr));
        check("rsv_lr", 64'(bus.rsv_lr), 64'(cur[g].lr));
        check("rsv_sc", 64'(bus.rsv_sc), 64'(cur[g].sc));
        check("rsv_store", 64'(bus.rsv_store), 64'(cur[g].st));
      end
      check("mem_valid", 64'(bus.mem_valid), 64'(m_full));
      if (m_full) begin
        check("mem_addr", 64'(bus.mem_addr), 64'(m_ent.addr));
        check("mem_id", 64'(bus.mem_id), 64'(m_id));
        check("mem_lr", 64'(bus.mem_lr), 64'(m_ent.lr));
        check("mem_sc", 64'(bus.mem_sc), 64'(m_ent.sc));
        check("mem_store", 64'(bus.mem_store), 64'(m_ent.st));
      end
      exp_done = m_abort || (m_full && bus.mem_ready && m_ent.sc);
      check("sc_done", 64'(bus.sc_done), 64'(exp_done));
      if (exp_done) begin
        check("sc_success", 64'(bus.sc_success), 64'(m_full));
        check("sc_done_id", 64'(bus.sc_done_id), 64'(m_id));
      end
    end
  end

  function automatic req_t rand_req();
    req_t r;
    r.addr = 30'($urandom);
    r.lr   = 1'b0;
    r.sc   = 1'b0;
    r.st   = 1'b0;
    case ($urandom_range(3))
      0:       ;
      1:       r.st = 1'b1;
      2:       r.lr = 1'b1;
      default: r.sc = 1'b1;
    endcase
    return r;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.req_valid[p]           = cur_v[p];
      bus.req_addr[p*30 +: 30]   = cur[p].addr;
      bus.req_lr[p]              = cur[p].lr;
      bus.req_sc[p]              = cur[p].sc;
      bus.req_store[p]           = cur[p].st;
    end
    bus.mem_ready = mem_ready_v;
    bus.rsv_abort = abort_v;
  endtask

  // One clock: retire granted requests, refill from the per-port queues, drive.
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (cur_v[p] && m_last_gnt[p]) cur_v[p] = 1'b0;
      if (rand_mode && !cur_v[p] && rq[p].size() == 0 && $urandom_range(99) < 40)
        rq[p].push_back(rand_req());
      if (!cur_v[p] && rq[p].size() > 0) begin
        cur[p]   = rq[p].pop_front();
        cur_v[p] = 1'b1;
      end
    end
    if (rand_mode) begin
      mem_ready_v = ($urandom_range(99) < 70);
      abort_v     = 1'($urandom_range(1));
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_sc_done", 64'(bus.sc_done), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsv_strobe", 64'(bus.rsv_strobe), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    int order [$];
    bit got;
    for (int p = 0; p < NP; p++) begin
      cur_v[p]  = 1'b0;
      cur[p]    = '{addr: 30'h0, lr: 1'b0, sc: 1'b0, st: 1'b0};
      m_wait[p] = 0;
    end
    drive();
    do_reset();

    // Single store from port 0.
    mem_ready_v = 1'b1;
    rq[0].push_back('{addr: 30'h100, lr: 1'b0, sc: 1'b0, st: 1'b1});
    step();
    @(negedge clk);
    check("t1_grant", 64'(bus.req_ready), 64'b001);
    step();
    @(negedge clk);
    check("t1_mem_valid", 64'(bus.mem_valid), 64'd1);
    check("t1_mem_addr", 64'(bus.mem_addr), 64'h100);
    check("t1_mem_store", 64'(bus.mem_store), 64'd1);
    check("t1_sc_done", 64'(bus.sc_done), 64'd0);
    repeat (3) step();

    // Two contending ports alternate from a freshly reset pointer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq[0].push_back('{addr: 30'(32'h1000 + i), lr: 1'b0, sc: 1'b0, st: 1'b0});
      rq[1].push_back('{addr: 30'(32'h2000 + i), lr: 1'b0, sc: 1'b0, st: 1'b1});
    end
    for (int c = 0; c < 30 && order.size() < 8; c++) begin
      step();
      @(negedge clk);
      check("t2_onehot0", 64'($countones(bus.req_ready) <= 1), 64'd1);
      for (int p = 0; p < NP; p++) if (bus.req_ready[p]) order.push_back(p);
    end
    check("t2_grant_count", 64'(order.size()), 64'd8);
    foreach (order[i]) check("t2_grant_order", 64'(order[i]), 64'(i % 2));
    repeat (3) step();

    // LR then SC from port 1, reservation intact.
    rq[1].push_back('{addr: 30'h40, lr: 1'b1, sc: 1'b0, st: 1'b0});
    rq[1].push_back('{addr: 30'h40, lr: 1'b0, sc: 1'b1, st: 1'b0});
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      @(negedge clk);
      if (bus.sc_done) begin
        got = 1'b1;
        break;
      end
    end
    check("t3_sc_done_seen", 64'(got), 64'd1);
    check("t3_sc_success", 64'(bus.sc_success), 64'd1);
    check("t3_sc_done_id", 64'(bus.sc_done_id), 64'd1);
    check("t3_mem_sc", 64'(bus.mem_sc), 64'd1);
    check("t3_mem_addr", 64'(bus.mem_addr), 64'h40);
    repeat (3) step();

    // SC from port 0 aborted; a load from port 1 is granted in the report cycle.
    abort_v = 1'b1;
    rq[0].push_back('{addr: 30'h80, lr: 1'b0, sc: 1'b1, st: 1'b0});
    step();
    @(negedge clk);
    check("t4_sc_grant", 64'(bus.req_ready), 64'b001);
    rq[1].push_back('{addr: 30'h90, lr: 1'b0, sc: 1'b0, st: 1'b0});
    step();
    @(negedge clk);
    check("t4_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("t4_sc_done", 64'(bus.sc_done), 64'd1);
    check("t4_sc_success", 64'(bus.sc_success), 64'd0);
    check("t4_sc_done_id", 64'(bus.sc_done_id), 64'd0);
    check("t4_next_grant", 64'(bus.req_ready), 64'b010);
    abort_v = 1'b0;
    step();
    @(negedge clk);
    check("t4_load_fwd", 64'(bus.mem_addr), 64'h90);
    check("t4_no_done", 64'(bus.sc_done), 64'd0);
    repeat (3) step();

    // Backpressure: port 0 load held while port 1 waits.
    rq[0].push_back('{addr: 30'h200, lr: 1'b0, sc: 1'b0, st: 1'b0});
    step();
    rq[1].push_back('{addr: 30'h300, lr: 1'b0, sc: 1'b0, st: 1'b0});
    mem_ready_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      check("t5_hold_valid", 64'(bus.mem_valid), 64'd1);
      check("t5_hold_addr", 64'(bus.mem_addr), 64'h200);
      check("t5_no_grant", 64'(bus.req_ready), 64'd0);
      check("t5_no_strobe", 64'(bus.rsv_strobe), 64'd0);
    end
    mem_ready_v = 1'b1;
    step();
    @(negedge clk);
    check("t5_release_grant", 64'(bus.req_ready), 64'b010);
    step();
    @(negedge clk);
    check("t5_next_addr", 64'(bus.mem_addr), 64'h300);
    repeat (3) step();

    // Reset while an entry is pending; pointer returns to port 0.
    mem_ready_v = 1'b0;
    rq[0].push_back('{addr: 30'h10, lr: 1'b0, sc: 1'b0, st: 1'b0});
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("t6_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("t6_sc_done", 64'(bus.sc_done), 64'd0);
    rst = 1'b0;
    mem_ready_v = 1'b1;
    rq[1].push_back('{addr: 30'h21, lr: 1'b0, sc: 1'b0, st: 1'b0});
    rq[0].push_back('{addr: 30'h20, lr: 1'b0, sc: 1'b0, st: 1'b0});
    step();
    @(negedge clk);
    check("t6_port0_wins", 64'(bus.req_ready), 64'b001);
    repeat (4) step();

    // Random traffic with random backpressure and reservation aborts.
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode   = 1'b0;
    mem_ready_v = 1'b1;
    abort_v     = 1'b0;
    for (int p = 0; p < NP; p++) rq[p].delete();
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!cur_v[0] && !cur_v[1] && !cur_v[2] && !m_full && !m_abort) begin
        got = 1'b1;
        break;
      end
    end
    check("drain_complete", 64'(got), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
